// File: rtl/wd_pkg.sv
// Types and timing defaults shared by the heartbeat generator and the watchdog timer.
package wd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STALE   = 2'd2,
        TRIPPED = 2'd3
    } hb_state_t;

    localparam int unsigned HB_COUNT_W       = 16;
    localparam int unsigned DEF_HB_PERIOD    = 12_500_000;  // 100 ms @ 125 MHz
    localparam int unsigned DEF_HOST_TIMEOUT = 125_000_000; // 1 s @ 125 MHz
    localparam int unsigned DEF_PULSE_WIDTH  = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Emits a registered pulse exactly WIDTH cycles long per accepted start; abort ends it at once.
module pulse_stretcher
    import wd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_PULSE_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic pulse,
    output logic busy
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LOAD = CW'(WIDTH - 1);

    logic [CW-1:0] remain;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            pulse  <= 1'b0;
            remain <= '0;
        end else if (pulse) begin
            // Starts arriving while high are dropped, never extending the pulse.
            if (remain == '0) begin
                pulse <= 1'b0;
            end else begin
                remain <= remain - CW'(1);
            end
        end else if (start) begin
            pulse  <= 1'b1;
            remain <= LOAD;
        end
    end

    assign busy = pulse;

endmodule

// File: rtl/heartbeat_generator.sv
// Periodic watchdog heartbeat source, withheld when the host link goes quiet; latches watchdog trips.
module heartbeat_generator
    import wd_pkg::*;
#(
    parameter int unsigned HB_PERIOD    = DEF_HB_PERIOD,
    parameter int unsigned HOST_TIMEOUT = DEF_HOST_TIMEOUT,
    parameter int unsigned PULSE_WIDTH  = DEF_PULSE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  host_activity,
    input  logic                  wd_warning,
    input  logic                  wd_triggered,
    input  logic                  fault_clear,
    output logic                  heartbeat,
    output logic [1:0]            hb_state,
    output logic                  host_alive,
    output logic [HB_COUNT_W-1:0] hb_count
);

    localparam int unsigned PW = cnt_width(HB_PERIOD);
    localparam int unsigned AW = cnt_width(HOST_TIMEOUT);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(HB_PERIOD - 1);
    localparam logic [AW-1:0] AGE_LAST    = AW'(HOST_TIMEOUT - 1);

    hb_state_t     state;
    logic [PW-1:0] period_cnt;
    logic [AW-1:0] age_cnt;
    logic          warn_q;
    logic          warn_rise;
    logic          period_tc;
    logic          abort;
    logic          start;
    logic          busy;

    always_comb begin
        warn_rise = wd_warning & ~warn_q;
        period_tc = (period_cnt == PERIOD_LAST);
        abort     = wd_triggered | ~enable;
        start     = (state == RUN) & ~abort & (period_tc | warn_rise) & ~busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            host_alive <= 1'b0;
            hb_count   <= '0;
            period_cnt <= '0;
            age_cnt    <= '0;
            warn_q     <= 1'b0;
        end else begin
            warn_q <= wd_warning;
            if (start) begin
                hb_count <= hb_count + HB_COUNT_W'(1);
            end

            if (wd_triggered) begin
                state      <= TRIPPED;
                host_alive <= 1'b0;
            end else if (state == TRIPPED) begin
                if (fault_clear) begin
                    state <= IDLE;
                end
            end else if (!enable) begin
                state      <= IDLE;
                host_alive <= 1'b0;
                period_cnt <= '0;
                age_cnt    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state      <= RUN;
                        host_alive <= 1'b1;
                        period_cnt <= '0;
                        age_cnt    <= '0;
                    end
                    RUN: begin
                        // A warning edge resynchronises the period even when its pulse is dropped.
                        if (period_tc || warn_rise) begin
                            period_cnt <= '0;
                        end else begin
                            period_cnt <= period_cnt + PW'(1);
                        end
                        if (host_activity) begin
                            age_cnt <= '0;
                        end else if (age_cnt == AGE_LAST) begin
                            state      <= STALE;
                            host_alive <= 1'b0;
                        end else begin
                            age_cnt <= age_cnt + AW'(1);
                        end
                    end
                    STALE: begin
                        if (host_activity) begin
                            state      <= RUN;
                            host_alive <= 1'b1;
                            period_cnt <= '0;
                            age_cnt    <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign hb_state = state;

    pulse_stretcher #(
        .WIDTH (PULSE_WIDTH)
    ) u_pulse (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .pulse (heartbeat),
        .busy  (busy)
    );

endmodule
